// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// A byte transfers on a rising edge where in_valid && in_ready; in_valid may drop at any time.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    // master: byte source that also observes the memory writes; slave: the loader
    modport master (output in_data, in_valid, input in_ready, mem_we, mem_addr, mem_wdata);
    modport slave  (input in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a 16-bit word-count header, assembles little-endian words and
// writes them to consecutive instruction-memory addresses, holding the CPU in reset meanwhile.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    imem_loader_if.slave   bus,
    output logic           cpu_rst,
    output logic           done,
    output logic           err,
    output logic [2:0]     fsm_state
);
    typedef enum logic [2:0] {
        HDR_LO = 3'd0,
        HDR_HI = 3'd1,
        DATA   = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4,
        ERROR  = 3'd5
    } state_t;

    localparam logic [16:0] CAPACITY = 17'(1) << ADDR_W;

    state_t            state, state_next;
    logic [15:0]       n_reg;
    logic [1:0]        byte_idx;
    logic [ADDR_W:0]   word_idx;
    logic [23:0]       asm_reg;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic              accept, hdr_zero, hdr_over, last_word;

    assign accept    = bus.in_valid && bus.in_ready;
    assign hdr_zero  = {bus.in_data, n_reg[7:0]} == 16'd0;
    assign hdr_over  = {1'b0, bus.in_data, n_reg[7:0]} > CAPACITY;
    // word_idx is one bit wider than the address so a full-capacity load is countable
    assign last_word = (17'(word_idx) + 17'd1) == {1'b0, n_reg};

    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign fsm_state     = state;

    always_ff @(posedge clk) begin
        if (rst) state <= HDR_LO;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            HDR_LO: if (accept) state_next = HDR_HI;
            HDR_HI: begin
                if (accept) begin
                    if (hdr_zero)      state_next = DONE;
                    else if (hdr_over) state_next = ERROR;
                    else               state_next = DATA;
                end
            end
            DATA:    if (accept && byte_idx == 2'd3 && last_word) state_next = FLUSH;
            FLUSH:   state_next = DONE;
            DONE:    state_next = DONE;
            ERROR:   state_next = ERROR;
            default: state_next = HDR_LO;
        endcase
    end

    always_comb begin
        bus.in_ready = 1'b0;
        cpu_rst      = 1'b1;
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            HDR_LO, HDR_HI, DATA: bus.in_ready = !rst;
            DONE: begin
                cpu_rst = 1'b0;
                done    = 1'b1;
            end
            ERROR:   err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_reg       <= '0;
            byte_idx    <= '0;
            word_idx    <= '0;
            asm_reg     <= '0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
        end else begin
            mem_we_r <= 1'b0;
            if (accept) begin
                case (state)
                    HDR_LO: n_reg[7:0] <= bus.in_data;
                    HDR_HI: begin
                        n_reg[15:8] <= bus.in_data;
                        byte_idx    <= '0;
                        word_idx    <= '0;
                    end
                    DATA: begin
                        byte_idx <= byte_idx + 2'd1;
                        case (byte_idx)
                            2'd0: asm_reg[7:0]   <= bus.in_data;
                            2'd1: asm_reg[15:8]  <= bus.in_data;
                            2'd2: asm_reg[23:16] <= bus.in_data;
                            default: begin
                                mem_we_r    <= 1'b1;
                                mem_addr_r  <= word_idx[ADDR_W-1:0];
                                mem_wdata_r <= {bus.in_data, asm_reg};
                                word_idx    <= word_idx + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, completion, error and reset.
module tb_imem_loader;
  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cpu_rst, done, err;
  logic [2:0] fsm_state;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .cpu_rst(cpu_rst),
    .done(done),
    .err(err),
    .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [31:0]       exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [31:0]       got_q[$];
  logic [ADDR_W-1:0] got_addr_q[$];

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      got_q.push_back(bus.mem_wdata);
      got_addr_q.push_back(bus.mem_addr);
    end
  end

  task automatic clear_logs();
    exp_q.delete(); exp_addr_q.delete(); got_q.delete(); got_addr_q.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (2) @(negedge clk);
    clear_logs();
    rst = 1'b0;
    #1;
  endtask

  // Drives one byte after gap idle cycles; returns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap, output int stalls);
    stalls = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data = b;
    #1;
    while (bus.in_ready !== 1'b1 && stalls < 20) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout byte=%h in_ready=%b want 1", b, bus.in_ready);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic send_word(input logic [31:0] w, input bit rand_gap, output int stalls);
    int s;
    stalls = 0;
    for (int i = 0; i < 4; i++) begin
      send_byte(w[8*i +: 8], rand_gap ? int'($urandom_range(0, 3)) : 0, s);
      stalls += s;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'hAA;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
    @(negedge clk);
    checks++;
    if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'h00 || bus.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem got we=%b addr=%h data=%h want 0 0 0", bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status got cpu_rst=%b done=%b err=%b want 1 0 0", cpu_rst, done, err);
    end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || fsm_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_release got in_ready=%b state=%0d want 1 0", bus.in_ready, fsm_state);
    end
  endtask

  task automatic test_load3(input bit rand_gap);
    logic [31:0] words [3];
    int s, total;
    words[0] = 32'h0000_0013; words[1] = 32'h0000_0013; words[2] = 32'h0340_0093;
    apply_reset();
    total = 0;
    send_byte(8'h03, 0, s); total += s;
    send_byte(8'h00, 0, s); total += s;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(words[i]);
      exp_addr_q.push_back(8'(i));
      send_word(words[i], rand_gap, s);
      total += s;
    end
    checks++;
    if (total != 0) begin errors++; $display("FAIL load3_stalls got %0d want 0", total); end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd2 || done !== 1'b0 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL load3_last_write got we=%b addr=%0d done=%b cpu_rst=%b want 1 2 0 1",
               bus.mem_we, bus.mem_addr, done, cpu_rst);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_we !== 1'b0 || done !== 1'b1 || cpu_rst !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load3_done got we=%b done=%b cpu_rst=%b in_ready=%b want 0 1 0 0",
               bus.mem_we, done, cpu_rst, bus.in_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL load3_count gap=%0d got %0d want %0d", rand_gap, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_addr_q[i] !== exp_addr_q[i]) begin
        errors++;
        $display("FAIL load3_word%0d got %h@%0d want %h@%0d", i, got_q[i], got_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_zero_count();
    int s;
    bit seen_ready;
    apply_reset();
    send_byte(8'h00, 0, s);
    send_byte(8'h00, 0, s);
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_done got done=%b cpu_rst=%b in_ready=%b want 1 0 0", done, cpu_rst, bus.in_ready);
    end
    seen_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'h10 + i);
      #1;
      if (bus.in_ready !== 1'b0) seen_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seen_ready || got_q.size() != 0 || done !== 1'b1) begin
      errors++;
      $display("FAIL zero_after got ready_seen=%b writes=%0d done=%b want 0 0 1", seen_ready, got_q.size(), done);
    end
  endtask

  task automatic test_error();
    int s;
    bit seen_ready;
    apply_reset();
    send_byte(8'h01, 0, s);
    send_byte(8'h01, 0, s);
    checks++;
    if (err !== 1'b1 || cpu_rst !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL error_state got err=%b cpu_rst=%b done=%b in_ready=%b want 1 1 0 0",
               err, cpu_rst, done, bus.in_ready);
    end
    seen_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data = 8'(8'hF0 + i);
      #1;
      if (bus.in_ready !== 1'b0) seen_ready = 1'b1;
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (seen_ready || got_q.size() != 0 || err !== 1'b1 || cpu_rst !== 1'b1) begin
      errors++;
      $display("FAIL error_after got ready_seen=%b writes=%0d err=%b cpu_rst=%b want 0 0 1 1",
               seen_ready, got_q.size(), err, cpu_rst);
    end
  endtask

  task automatic test_full_load();
    int s;
    logic [31:0] w;
    apply_reset();
    send_byte(8'h00, 0, s);
    send_byte(8'h01, 0, s);
    for (int i = 0; i < 256; i++) begin
      w = 32'hC0DE_0000 | 32'(i * 3);
      exp_q.push_back(w);
      exp_addr_q.push_back(8'(i));
      send_word(w, 1'b0, s);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'd255 || done !== 1'b0) begin
      errors++;
      $display("FAIL full_last got we=%b addr=%0d done=%b want 1 255 0", bus.mem_we, bus.mem_addr, done);
    end
    @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done=%b cpu_rst=%b err=%b want 1 0 0", done, cpu_rst, err);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (got_q.size() != 256) begin errors++; $display("FAIL full_count got %0d want 256", got_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i] || got_addr_q[i] !== exp_addr_q[i]) begin
        errors++;
        $display("FAIL full_word%0d got %h@%0d want %h@%0d", i, got_q[i], got_addr_q[i], exp_q[i], exp_addr_q[i]);
      end
    end
  endtask

  task automatic test_rst_mid_load();
    int s;
    logic [7:0] fresh [6];
    fresh[0] = 8'h01; fresh[1] = 8'h00; fresh[2] = 8'h93;
    fresh[3] = 8'h00; fresh[4] = 8'h40; fresh[5] = 8'h03;
    apply_reset();
    send_byte(8'h03, 0, s);
    send_byte(8'h00, 0, s);
    send_word(32'h0000_0013, 1'b0, s);
    send_word(32'h0000_0013, 1'b0, s);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (cpu_rst !== 1'b1 || done !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_hold got cpu_rst=%b done=%b in_ready=%b want 1 0 0", cpu_rst, done, bus.in_ready);
    end
    clear_logs();
    rst = 1'b0;
    #1;
    checks++;
    if (fsm_state !== 3'd0 || cpu_rst !== 1'b1 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_release got state=%0d cpu_rst=%b in_ready=%b want 0 1 1", fsm_state, cpu_rst, bus.in_ready);
    end
    exp_q.push_back(32'h0340_0093);
    exp_addr_q.push_back(8'd0);
    for (int i = 0; i < 6; i++) send_byte(fresh[i], 0, s);
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || cpu_rst !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_done got done=%b cpu_rst=%b want 1 0", done, cpu_rst);
    end
    checks++;
    if (got_q.size() != 1) begin
      errors++;
      $display("FAIL rstmid_count got %0d want 1", got_q.size());
    end else if (got_q[0] !== exp_q[0] || got_addr_q[0] !== exp_addr_q[0]) begin
      errors++;
      $display("FAIL rstmid_word got %h@%0d want %h@%0d", got_q[0], got_addr_q[0], exp_q[0], exp_addr_q[0]);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    test_reset();
    test_load3(1'b0);
    test_load3(1'b1);
    test_zero_count();
    test_error();
    test_full_load();
    test_rst_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that fills instruction memory before the CPU runs. Accepts a byte stream (valid/ready) carrying a word-count header followed by little-endian instruction words, writes each assembled word into consecutive instruction-memory locations through a write port, and holds the CPU in reset until the load completes. It sits between a host byte source (UART receiver, debug bridge or testbench) and the write side of `inst_mem`, complementing the CPU's read-only fetch port.

## Interface

Parameters:
- `ADDR_W`, 8, word-address width of the instruction memory. Capacity is 2^ADDR_W words; the default of 256 matches `inst_mem`.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader accepts a byte this cycle.
- `mem_we`  output  1  instruction-memory write strobe, one cycle per word.
- `mem_addr`  output  ADDR_W  word address (byte address = `mem_addr` << 2).
- `mem_wdata`  output  32  word to write.
- `cpu_rst`  output  1  reset to the CPU; high until the load completes.
- `done`  output  1  load completed (sticky until `rst`).
- `err`  output  1  header word count exceeds capacity (sticky until `rst`).

## Operation

- Handshake: a byte is accepted on a rising edge where `in_valid && in_ready`. `in_valid` may drop at any time. `in_data` is ignored when no byte is accepted.
- Stream format: header byte N[7:0], then N[15:8], then 4*N data bytes. Each word is sent least-significant byte first.
- States:
  - HDR_LO: `in_ready` = 1. On accept, latch N[7:0] and go to HDR_HI.
  - HDR_HI: `in_ready` = 1. On accept, latch N[15:8], then:
    - N == 0 → DONE.
    - N > 2^ADDR_W → ERROR.
    - otherwise → DATA, with byte index = 0 and word index = 0.
  - DATA: `in_ready` = 1.
    - Each accept shifts the byte into the assembly register at lane byte_idx, and byte_idx increments modulo 4.
    - On the accept with byte_idx == 3, register the word: `mem_wdata` = assembled word, `mem_addr` = word index, `mem_we` = 1 in the following cycle. Then increment word index.
    - If that was word N-1, go to FLUSH; otherwise stay in DATA.
  - FLUSH: `in_ready` = 0. This is the cycle in which the final `mem_we` is high; go to DONE.
  - DONE: `in_ready` = 0, `cpu_rst` = 0, `done` = 1. Terminal.
  - ERROR: `in_ready` = 0, `cpu_rst` = 1, `err` = 1. Terminal; no writes are issued.
- `in_ready` is combinational from the state and is forced to 0 while `rst` = 1.
- Word index is ADDR_W+1 bits wide so that N = 2^ADDR_W is reachable. `mem_addr` carries the low ADDR_W bits; the last write goes to 2^ADDR_W − 1 with no wrap.
- Bytes arriving after DONE or ERROR are not accepted (`in_ready` = 0).

## Timing

- Reset values (while `rst` = 1 and on the first cycle after it): `in_ready` = 0 during `rst`; state = HDR_LO; `mem_we` = 0; `mem_addr` = 0; `mem_wdata` = 0; `cpu_rst` = 1; `done` = 0; `err` = 0.
- `in_ready` = 1 in the first cycle after `rst` falls.
- Write latency: the 4th byte of a word is accepted at edge k. `mem_we`, `mem_addr` and `mem_wdata` are valid from edge k to edge k+1. `mem_we` is never high on two cycles for the same word.
- Back-to-back bytes give at most one write every 4 cycles. In DATA, `in_ready` stays high during a write cycle, so the next word's first byte can be accepted concurrently with that write.
- Completion: the final byte is accepted at edge k, `mem_we` is high in cycle k..k+1, and `done` = 1 and `cpu_rst` = 0 after edge k+1. The CPU therefore never leaves reset before the last word is written.
- N == 0: `done` = 1 and `cpu_rst` = 0 from the edge that accepts N[15:8].
- Error: `err` = 1 from the edge that accepts N[15:8].
- `rst` asserted mid-load: all state returns to HDR_LO and the counters clear. Memory words already written are not erased, `cpu_rst` stays 1, and a new stream is required.

## Test plan

- Load N=3 with words 0x00000013, 0x00000013, 0x03400093, back-to-back bytes → exactly three `mem_we` pulses at addr 0, 1, 2 with those values. `done` rises and `cpu_rst` falls one cycle after the last pulse. A CPU attached to the filled memory then ends with xreg[1] == 0x34.
- Same stream with `in_valid` gaps of 0–3 random cycles between bytes → identical writes, with no extra or duplicated `mem_we`.
- Header N=0 (bytes 0x00, 0x00) → no `mem_we`. `done` = 1 and `cpu_rst` = 0 the cycle after the second header byte; `in_ready` = 0 thereafter.
- With ADDR_W=8, header N=257 (0x01, 0x01) → `err` = 1, `cpu_rst` stays 1, `in_ready` = 0, and no writes even if data bytes keep arriving.
- Full load N=256 → the last write is at addr 255 (no wrap to 0), followed by `done`.
- `rst` pulsed after 2 of 3 words → `cpu_rst` stays 1 and `done` = 0. A fresh N=1 stream (0x01, 0x00, 0x93, 0x00, 0x40, 0x03) writes 0x03400093 at addr 0 and then completes.
